// File: rtl/mcu_rvjtag_tap_mc.sv
// mcu_rvjtag_tap_mc: clk-oversampled JTAG TAP with IDCODE, BYPASS and NCH RISC-V DTMCS/DMI channel pairs
module mcu_rvjtag_tap_mc #(
    parameter int AWIDTH = 7,
    parameter int IRLEN = 5,
    parameter int NCH = 2,
    parameter logic [2:0] IDLE_HINT = 3'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdoEnable,
    input  logic [31:1]           jtag_id,
    input  logic [3:0]            version,
    output logic [NCH-1:0]        dmi_req_valid,
    input  logic [NCH-1:0]        dmi_req_ready,
    output logic [NCH*AWIDTH-1:0] dmi_req_addr,
    output logic [NCH*32-1:0]     dmi_req_data,
    output logic [NCH*2-1:0]      dmi_req_op,
    input  logic [NCH-1:0]        dmi_rsp_valid,
    input  logic [NCH*32-1:0]     dmi_rsp_data,
    input  logic [NCH*2-1:0]      dmi_rsp_status,
    output logic [NCH-1:0]        dmi_reset,
    output logic [NCH-1:0]        dmi_hard_reset
);
    localparam int SW = AWIDTH + 34;
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } state_t;
    state_t state, state_n;
    logic tck_q, rise, fall, upd, is_id, is_dtm, is_dmi, sel_sticky;
    logic [SW-1:0] sr, sr_n, dr_cap, dr_sh;
    logic [IRLEN-1:0] ir;
    logic [NCH-1:0] pending, sticky, dtm_hit, dmi_hit, go_v, soft_v, hard_v;
    logic [31:0] rdata [NCH];
    logic [1:0] rsp_st [NCH];
    logic [AWIDTH-1:0] sel_addr;
    logic [31:0] sel_rdata, dtmcs_cap;
    logic [1:0] sel_st;
    assign rise = tck & ~tck_q;
    assign fall = ~tck & tck_q;
    assign upd = rise && state == UPD_DR;
    assign is_id = ir == IRLEN'(1);
    assign is_dtm = |dtm_hit;
    assign is_dmi = |dmi_hit;
    assign go_v = {NCH{upd && sr[1:0] != 2'd0}} & dmi_hit;
    assign soft_v = {NCH{upd && (sr[16] || sr[17])}} & dtm_hit;
    assign hard_v = {NCH{upd && sr[17]}} & dtm_hit;
    always_comb begin
        dtm_hit = '0;
        dmi_hit = '0;
        sel_sticky = 1'b0;
        sel_addr = '0;
        sel_rdata = '0;
        sel_st = 2'd0;
        for (int c = 0; c < NCH; c++) begin
            dtm_hit[c] = ir == IRLEN'(16 + 2 * c);
            dmi_hit[c] = ir == IRLEN'(17 + 2 * c);
            if (dtm_hit[c] || dmi_hit[c]) begin
                sel_sticky = sticky[c];
                sel_addr = dmi_req_addr[c*AWIDTH +: AWIDTH];
                sel_rdata = rdata[c];
                sel_st = (sticky[c] || pending[c]) ? 2'd3 : rsp_st[c];
            end
        end
    end
    always_comb begin
        dtmcs_cap = {17'b0, IDLE_HINT, sel_sticky ? 2'd3 : 2'd0, 6'(AWIDTH), version};
        dr_cap = is_dmi ? {sel_addr, sel_rdata, sel_st}
               : is_dtm ? SW'(dtmcs_cap)
               : is_id ? SW'({jtag_id, 1'b1}) : '0;
        // tdi enters at the top of whichever register is selected, so tdo length matches the DR
        dr_sh = is_dmi ? {tdi, sr[SW-1:1]}
              : (is_dtm || is_id) ? SW'({tdi, sr[31:1]}) : SW'(tdi);
        sr_n = !rise ? sr
             : state == CAP_IR ? SW'(2'b01)
             : state == SH_IR ? SW'({tdi, sr[IRLEN-1:1]})
             : state == CAP_DR ? dr_cap
             : state == SH_DR ? dr_sh : sr;
    end
    always_comb begin
        state_n = state;
        if (rise) begin
            case (state)
                TLR:     state_n = tms ? TLR : RTI;
                RTI:     state_n = tms ? SEL_DR : RTI;
                SEL_DR:  state_n = tms ? SEL_IR : CAP_DR;
                CAP_DR:  state_n = tms ? EX1_DR : SH_DR;
                SH_DR:   state_n = tms ? EX1_DR : SH_DR;
                EX1_DR:  state_n = tms ? UPD_DR : PA_DR;
                PA_DR:   state_n = tms ? EX2_DR : PA_DR;
                EX2_DR:  state_n = tms ? UPD_DR : SH_DR;
                UPD_DR:  state_n = tms ? SEL_DR : RTI;
                SEL_IR:  state_n = tms ? TLR : CAP_IR;
                CAP_IR:  state_n = tms ? EX1_IR : SH_IR;
                SH_IR:   state_n = tms ? EX1_IR : SH_IR;
                EX1_IR:  state_n = tms ? UPD_IR : PA_IR;
                PA_IR:   state_n = tms ? EX2_IR : PA_IR;
                EX2_IR:  state_n = tms ? UPD_IR : SH_IR;
                UPD_IR:  state_n = tms ? SEL_DR : RTI;
                default: state_n = TLR;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TLR;
            tck_q <= 1'b0;
            sr <= '0;
            ir <= IRLEN'(1);
            tdo <= 1'b0;
            tdoEnable <= 1'b0;
            pending <= '0;
            sticky <= '0;
            dmi_req_valid <= '0;
            dmi_req_addr <= '0;
            dmi_req_data <= '0;
            dmi_req_op <= '0;
            dmi_reset <= '0;
            dmi_hard_reset <= '0;
            for (int c = 0; c < NCH; c++) begin
                rdata[c] <= '0;
                rsp_st[c] <= '0;
            end
        end else begin
            tck_q <= tck;
            state <= state_n;
            sr <= sr_n;
            tdoEnable <= state == SH_DR || state == SH_IR;
            if (fall) tdo <= sr[0];
            if (state == TLR) ir <= IRLEN'(1);
            else if (fall && state == UPD_IR) ir <= (sr == '0) ? '1 : sr[IRLEN-1:0];
            dmi_reset <= soft_v;
            dmi_hard_reset <= hard_v;
            for (int c = 0; c < NCH; c++) begin
                if (dmi_req_valid[c] && dmi_req_ready[c]) dmi_req_valid[c] <= 1'b0;
                if (dmi_rsp_valid[c] && pending[c] && !hard_v[c]) begin
                    rdata[c] <= dmi_rsp_data[c*32 +: 32];
                    rsp_st[c] <= dmi_rsp_status[c*2 +: 2];
                    pending[c] <= 1'b0;
                end
                if (go_v[c]) begin
                    if (pending[c] || sticky[c]) sticky[c] <= 1'b1;
                    else begin
                        dmi_req_addr[c*AWIDTH +: AWIDTH] <= sr[SW-1:34];
                        dmi_req_data[c*32 +: 32] <= sr[33:2];
                        dmi_req_op[c*2 +: 2] <= sr[1:0];
                        pending[c] <= 1'b1;
                        dmi_req_valid[c] <= 1'b1;
                    end
                end
                if (soft_v[c]) sticky[c] <= 1'b0;
                if (hard_v[c]) begin
                    pending[c] <= 1'b0;
                    dmi_req_valid[c] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mcu_rvjtag_tap_mc.sv
// tb_mcu_rvjtag_tap_mc: table-driven JTAG scans plus DMI request scoreboard for mcu_rvjtag_tap_mc
module tb_mcu_rvjtag_tap_mc;
    logic clk = 1'b0, rst, tck, tms, tdi, tdo, tdoEnable;
    logic [31:1] jtag_id;
    logic [3:0] version;
    logic [1:0] dmi_req_valid, dmi_req_ready, dmi_rsp_valid, dmi_reset, dmi_hard_reset;
    logic [13:0] dmi_req_addr;
    logic [63:0] dmi_req_data, dmi_rsp_data;
    logic [3:0] dmi_req_op, dmi_rsp_status;
    int checks = 0, failures = 0;
    int nreset [2] = '{0, 0};
    int nhard [2] = '{0, 0};
    typedef struct {int ch; logic [6:0] addr; logic [31:0] data; logic [1:0] op;} req_t;
    typedef struct {logic [4:0] ir; int n; logic [40:0] din; logic [40:0] dout;} vec_t;
    req_t exp_q[$];
    req_t mon_e;
    vec_t vecs [7];

    mcu_rvjtag_tap_mc dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdoEnable(tdoEnable),
        .jtag_id(jtag_id), .version(version),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready), .dmi_req_addr(dmi_req_addr),
        .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_status(dmi_rsp_status),
        .dmi_reset(dmi_reset), .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Counts reset pulses and pops the scoreboard on every accepted request
    always @(negedge clk) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            if (dmi_reset[c]) nreset[c]++;
            if (dmi_hard_reset[c]) nhard[c]++;
            if (dmi_req_valid[c] && dmi_req_ready[c]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req actual=ch%0d required=none", c);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("req_ch", 64'(c), 64'(mon_e.ch));
                    check("req_addr", 64'(dmi_req_addr[c*7 +: 7]), 64'(mon_e.addr));
                    check("req_data", 64'(dmi_req_data[c*32 +: 32]), 64'(mon_e.data));
                    check("req_op", 64'(dmi_req_op[c*2 +: 2]), 64'(mon_e.op));
                end
            end
        end
    end

    task automatic tck_cyc(input logic m, input logic d, output logic o, output logic en);
        tms = m;
        tdi = d;
        repeat (4) @(negedge clk);
        o = tdo;
        en = tdoEnable;
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic jshift(input logic irp, input int n, input logic [40:0] din,
                          output logic [40:0] dout, output int enerr);
        logic o, en;
        dout = '0;
        enerr = 0;
        tck_cyc(1'b1, 1'b0, o, en); enerr += int'(en);
        if (irp) begin tck_cyc(1'b1, 1'b0, o, en); enerr += int'(en); end
        tck_cyc(1'b0, 1'b0, o, en); enerr += int'(en);
        tck_cyc(1'b0, 1'b0, o, en); enerr += int'(en);
        for (int i = 0; i < n; i++) begin
            tck_cyc(i == n - 1, din[i], o, en);
            dout[i] = o;
            enerr += int'(!en);
        end
        tck_cyc(1'b1, 1'b0, o, en); enerr += int'(en);
        tck_cyc(1'b0, 1'b0, o, en); enerr += int'(en);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [40:0] d;
        int e;
        jshift(1'b1, 5, 41'(v), d, e);
        check("ir_capture", d, 64'h1);
        check("ir_tdo_enable", 64'(e), 64'd0);
    endtask

    task automatic dr(input int n, input logic [40:0] din, output logic [40:0] dout);
        int e;
        jshift(1'b0, n, din, dout, e);
        check("dr_tdo_enable", 64'(e), 64'd0);
    endtask

    initial begin
        logic [40:0] d;
        logic o, en;
        int r0, h0;
        vecs[0] = '{5'h01, 32, 41'h0, 41'h45};
        vecs[1] = '{5'h12, 32, 41'h0, 41'h1071};
        vecs[2] = '{5'h10, 32, 41'h0, 41'h1071};
        vecs[3] = '{5'h00, 8, 41'hB3, 41'h66};
        vecs[4] = '{5'h15, 8, 41'h5A, 41'hB4};
        vecs[5] = '{5'h11, 41, 41'h0, 41'h0};
        vecs[6] = '{5'h1F, 4, 41'hF, 41'hE};
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
        jtag_id = 31'h0000_0022; version = 4'd1;
        dmi_req_ready = '0; dmi_rsp_valid = '0; dmi_rsp_data = '0; dmi_rsp_status = '0;
        repeat (3) @(negedge clk);
        check("rst_tdo", 64'(tdo), 0);
        check("rst_tdo_enable", 64'(tdoEnable), 0);
        check("rst_valid", 64'(dmi_req_valid), 0);
        check("rst_state", 64'(dut.state), 0);
        check("rst_ir", 64'(dut.ir), 1);
        rst = 1'b0;
        repeat (5) tck_cyc(1'b1, 1'b0, o, en);
        check("tlr_state", 64'(dut.state), 0);
        tck_cyc(1'b0, 1'b0, o, en);

        for (int i = 0; i < 7; i++) begin
            set_ir(vecs[i].ir);
            check($sformatf("vec%0d_ir", i), 64'(dut.ir), (vecs[i].ir == 5'h0) ? 64'h1F : 64'(vecs[i].ir));
            dr(vecs[i].n, vecs[i].din, d);
            check($sformatf("vec%0d_dout", i), d, vecs[i].dout);
        end

        // DMI write on channel 1, held while ready is low
        set_ir(5'h13);
        dr(41, {7'h10, 32'hDEAD_BEEF, 2'd2}, d);
        exp_q.push_back('{1, 7'h10, 32'hDEAD_BEEF, 2'd2});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ch1_valid_hold", 64'(dmi_req_valid), 64'b10);
            check("ch1_addr_hold", 64'(dmi_req_addr[13:7]), 64'h10);
            check("ch1_data_hold", 64'(dmi_req_data[63:32]), 64'hDEAD_BEEF);
            check("ch1_op_hold", 64'(dmi_req_op[3:2]), 64'd2);
            check("ch0_quiet", {dmi_req_addr[6:0], dmi_req_data[31:0], dmi_req_op[1:0]}, 0);
        end
        dmi_req_ready[1] = 1'b1;
        @(negedge clk);
        dmi_req_ready[1] = 1'b0;
        check("ch1_valid_drop", 64'(dmi_req_valid), 0);
        dmi_rsp_valid[1] = 1'b1; dmi_rsp_data[63:32] = 32'hCAFE_0001; dmi_rsp_status[3:2] = 2'd0;
        @(negedge clk);
        dmi_rsp_valid = '0;

        // Channel 0 read outstanding, a second update goes sticky
        set_ir(5'h11);
        dr(41, {7'h05, 32'h0, 2'd1}, d);
        check("ch0_cap_idle", d, 0);
        exp_q.push_back('{0, 7'h05, 32'h0, 2'd1});
        dr(41, {7'h06, 32'h1111, 2'd2}, d);
        check("ch0_cap_pending", d, {7'h05, 32'h0, 2'd3});
        check("ch0_valid_kept", 64'(dmi_req_valid), 64'b01);
        check("ch0_addr_kept", 64'(dmi_req_addr[6:0]), 64'h05);
        check("ch0_op_kept", 64'(dmi_req_op[1:0]), 64'd1);
        dr(41, 41'h0, d);
        check("ch0_cap_sticky", d, {7'h05, 32'h0, 2'd3});
        set_ir(5'h10);
        r0 = nreset[0]; h0 = nhard[0];
        dr(32, 41'h1_0000, d);
        check("dtm0_sticky", d, 41'h1C71);
        check("dmi_reset0_pulses", 64'(nreset[0] - r0), 1);
        check("dmi_hard0_none", 64'(nhard[0] - h0), 0);
        dr(32, 41'h0, d);
        check("dtm0_cleared", d, 41'h1071);
        dmi_req_ready[0] = 1'b1;
        @(negedge clk);
        dmi_req_ready[0] = 1'b0;
        dmi_rsp_valid[0] = 1'b1; dmi_rsp_data[31:0] = 32'hA5A5_0000; dmi_rsp_status[1:0] = 2'd2;
        @(negedge clk);
        dmi_rsp_valid = '0;
        set_ir(5'h11);
        dr(41, 41'h0, d);
        check("ch0_cap_rsp", d, {7'h05, 32'hA5A5_0000, 2'd2});

        // Channel 1 hard reset abandons an outstanding request
        set_ir(5'h13);
        dr(41, {7'h22, 32'h77, 2'd2}, d);
        check("ch1_cap_rsp", d, {7'h10, 32'hCAFE_0001, 2'd0});
        check("ch1_valid_new", 64'(dmi_req_valid), 64'b10);
        check("ch1_addr_new", 64'(dmi_req_addr[13:7]), 64'h22);
        set_ir(5'h12);
        r0 = nreset[1]; h0 = nhard[1];
        dr(32, 41'h2_0000, d);
        check("dtm1_cap", d, 41'h1071);
        check("ch1_valid_hard", 64'(dmi_req_valid), 0);
        check("dmi_hard1_pulses", 64'(nhard[1] - h0), 1);
        check("dmi_reset1_pulses", 64'(nreset[1] - r0), 1);
        dmi_rsp_valid[1] = 1'b1; dmi_rsp_data[63:32] = 32'h0000_1234; dmi_rsp_status[3:2] = 2'd1;
        @(negedge clk);
        dmi_rsp_valid = '0;
        set_ir(5'h13);
        dr(41, 41'h0, d);
        check("ch1_late_rsp_ignored", d, {7'h22, 32'hCAFE_0001, 2'd0});

        // Five tms=1 rises from Shift-DR return to Test-Logic-Reset
        tck_cyc(1'b1, 1'b0, o, en);
        tck_cyc(1'b0, 1'b0, o, en);
        tck_cyc(1'b0, 1'b0, o, en);
        repeat (5) tck_cyc(1'b1, 1'b0, o, en);
        check("tlr_from_shift", 64'(dut.state), 0);
        check("tlr_ir", 64'(dut.ir), 1);
        tck_cyc(1'b0, 1'b0, o, en);

        // Reset in the middle of a DMI write scan
        set_ir(5'h11);
        tck_cyc(1'b1, 1'b0, o, en);
        tck_cyc(1'b0, 1'b0, o, en);
        tck_cyc(1'b0, 1'b0, o, en);
        for (int i = 0; i < 20; i++) tck_cyc(1'b0, 1'b1, o, en);
        check("midshift_enable", 64'(tdoEnable), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(dmi_req_valid), 0);
        check("mid_rst_fields", {dmi_req_addr, dmi_req_data[49:0]}, 0);
        check("mid_rst_data_hi", 64'(dmi_req_data[63:50]), 0);
        check("mid_rst_op", 64'(dmi_req_op), 0);
        check("mid_rst_pulses", 64'({dmi_reset, dmi_hard_reset}), 0);
        check("mid_rst_tdo", 64'({tdo, tdoEnable}), 0);
        check("mid_rst_state", 64'(dut.state), 0);
        check("mid_rst_ir", 64'(dut.ir), 1);
        repeat (10) @(negedge clk);
        check("post_rst_valid", 64'(dmi_req_valid), 0);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
